result_bram_arbiter: RTL and testbench

RESULT_BRAM_ARBITER -- requirements
Module: result_bram_arbiter

---
 rtl/result_bram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_result_bram_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_bram_arbiter.sv
// Round-robin arbiter that grants NUM_REQ writers fixed-length bursts into
// per-requester circular regions of a shared result BRAM.
module result_bram_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned ADDRESS_WIDTH = 13,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned BURST_LEN     = 16,
    parameter int unsigned REGION_WORDS  = 512,
    parameter int unsigned RESULT_BASE   = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clear_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ-1:0]              valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    output logic [NUM_REQ-1:0]              done_o,
    output logic                            busy_o,
    output logic [ADDRESS_WIDTH-1:0]        bram_addr,
    output logic [DATA_WIDTH-1:0]           bram_din,
    output logic                            bram_en,
    output logic                            bram_we
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = (REGION_WORDS > 1) ? $clog2(REGION_WORDS) : 1;
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic [IDX_W-1:0]        gidx_q, gidx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]        wptr_q [NUM_REQ];
    logic [PTR_W-1:0]        wptr_d [NUM_REQ];
    logic                    clr_pend_q, clr_pend_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    en_q, en_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;

    logic                    pick_vld;
    logic [IDX_W-1:0]        pick_idx;
    logic [IDX_W-1:0]        cand;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   beat_data;

    // Cyclic first-set search starting at the round-robin pointer.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(rr_q) + i) % NUM_REQ);
            if (!pick_vld && req_i[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign accept    = (state_q == BURST) && valid_i[gidx_q];
    assign beat_data = data_i[32'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        gidx_d     = gidx_q;
        cnt_d      = cnt_q;
        wptr_d     = wptr_q;
        clr_pend_d = clr_pend_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        en_d       = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;

        case (state_q)
            IDLE: begin
                if (clear_i) begin
                    for (int unsigned k = 0; k < NUM_REQ; k++) wptr_d[k] = '0;
                end
                if (pick_vld) begin
                    state_d = BURST;
                    gidx_d  = pick_idx;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (clear_i) clr_pend_d = 1'b1;
                if (accept) begin
                    en_d   = 1'b1;
                    din_d  = beat_data;
                    addr_d = ADDRESS_WIDTH'(RESULT_BASE)
                           + ADDRESS_WIDTH'(32'(gidx_q) * REGION_WORDS)
                           + ADDRESS_WIDTH'(wptr_q[gidx_q]);
                    wptr_d[gidx_q] = wptr_q[gidx_q] + PTR_W'(1);
                    cnt_d          = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d = DONE;
                        gnt_d   = '0;
                        done_d  = gnt_q;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                rr_d       = IDX_W'((32'(gidx_q) + 1) % NUM_REQ);
                clr_pend_d = 1'b0;
                // A clear seen during the burst (or right now) lands as we go idle.
                if (clr_pend_q || clear_i) begin
                    for (int unsigned k = 0; k < NUM_REQ; k++) wptr_d[k] = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            gidx_q     <= '0;
            cnt_q      <= '0;
            for (int unsigned k = 0; k < NUM_REQ; k++) wptr_q[k] <= '0;
            clr_pend_q <= 1'b0;
            gnt_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            en_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            gidx_q     <= gidx_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            clr_pend_q <= clr_pend_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            en_q       <= en_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign done_o    = done_q;
    assign busy_o    = busy_q;
    assign bram_en   = en_q;
    assign bram_we   = en_q;
    assign bram_addr = addr_q;
    assign bram_din  = din_q;

endmodule

// File: tb/tb_result_bram_arbiter.sv
// Directed and randomized checks of result_bram_arbiter against a
// transaction-level model of grants, region pointers and BRAM writes.
module tb_result_bram_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int BL = 16;
    localparam int RW = 512;
    localparam int AW = 13;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic [N-1:0]      req;
    logic [N-1:0]      valid;
    logic [N*DW-1:0]   data;
    logic [N-1:0]      gnt_o;
    logic [N-1:0]      done_o;
    logic              busy_o;
    logic [AW-1:0]     bram_addr;
    logic [DW-1:0]     bram_din;
    logic              bram_en;
    logic              bram_we;

    result_bram_arbiter dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .clear_i  (clear),
        .req_i    (req),
        .valid_i  (valid),
        .data_i   (data),
        .gnt_o    (gnt_o),
        .done_o   (done_o),
        .busy_o   (busy_o),
        .bram_addr(bram_addr),
        .bram_din (bram_din),
        .bram_en  (bram_en),
        .bram_we  (bram_we)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: who owns the BRAM, beats left, region pointers.
    int          m_cur;
    int          m_left;
    int          m_ptr;
    bit          m_fin;
    bit          m_clr;
    int          m_wp [N];
    logic [N-1:0]  e_gnt;
    logic [N-1:0]  e_done;
    logic          e_busy;
    logic          e_en;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;

    int          wlog [$];
    int          glog [$];
    logic [N-1:0] prev_gnt;
    int          n_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_cur = -1; m_left = 0; m_ptr = 0; m_fin = 0; m_clr = 0;
        for (int i = 0; i < N; i++) m_wp[i] = 0;
        e_gnt = '0; e_done = '0; e_busy = 0; e_en = 0; e_addr = '0; e_din = '0;
    endfunction

    function automatic void model_edge(input logic [N-1:0] r, input logic [N-1:0] v,
                                       input logic c, input logic [N*DW-1:0] d);
        bit found;
        e_en   = 0;
        e_done = '0;
        if (m_fin) begin
            m_ptr = (m_cur + 1) % N;
            if (m_clr || c) for (int i = 0; i < N; i++) m_wp[i] = 0;
            m_clr = 0; m_fin = 0; m_cur = -1; e_busy = 0;
        end else if (m_cur >= 0) begin
            if (c) m_clr = 1;
            if (v[m_cur]) begin
                e_en   = 1;
                e_addr = AW'((m_cur * RW + m_wp[m_cur]) % (1 << AW));
                e_din  = d[m_cur*DW +: DW];
                m_wp[m_cur] = (m_wp[m_cur] + 1) % RW;
                m_left--;
                if (m_left == 0) begin
                    m_fin  = 1;
                    e_gnt  = '0;
                    e_done = N'(1 << m_cur);
                end
            end
        end else begin
            if (c) for (int i = 0; i < N; i++) m_wp[i] = 0;
            found = 0;
            for (int i = 0; i < N; i++) begin
                if (!found && r[(m_ptr + i) % N]) begin
                    found = 1;
                    m_cur = (m_ptr + i) % N;
                end
            end
            if (found) begin
                m_left = BL;
                e_gnt  = N'(1 << m_cur);
                e_busy = 1;
            end
        end
    endfunction

    function automatic int oh2i(input logic [N-1:0] g);
        int r = -1;
        for (int i = 0; i < N; i++) if (g[i]) r = i;
        return r;
    endfunction

    function automatic int wget(input int i);
        return (i < wlog.size()) ? wlog[i] : -1;
    endfunction

    // One clock: drive at negedge, predict, compare 1 time unit after posedge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] v, input logic c);
        req = r; valid = v; clear = c;
        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(posedge clk);
        model_edge(r, v, c, data);
        #1;
        chk("gnt",  32'(gnt_o),     32'(e_gnt));
        chk("done", 32'(done_o),    32'(e_done));
        chk("busy", 32'(busy_o),    32'(e_busy));
        chk("en",   32'(bram_en),   32'(e_en));
        chk("we",   32'(bram_we),   32'(e_en));
        chk("addr", 32'(bram_addr), 32'(e_addr));
        chk("din",  32'(bram_din),  32'(e_din));
        if (bram_en === 1'b1) wlog.push_back(int'(bram_addr));
        if (done_o !== '0) n_done++;
        if (gnt_o !== '0 && prev_gnt === '0) glog.push_back(oh2i(gnt_o));
        prev_gnt = gnt_o;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt",  32'(gnt_o),     32'd0);
        chk("rst_done", 32'(done_o),    32'd0);
        chk("rst_busy", 32'(busy_o),    32'd0);
        chk("rst_en",   32'(bram_en),   32'd0);
        chk("rst_we",   32'(bram_we),   32'd0);
        chk("rst_addr", 32'(bram_addr), 32'd0);
        chk("rst_din",  32'(bram_din),  32'd0);
        model_reset();
        prev_gnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] v;
        logic         tog;
        rst_n = 1'b1; req = '0; valid = '0; clear = 1'b0; data = '0;
        prev_gnt = '0; n_done = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single requester, back-to-back beats
        wlog.delete(); n_done = 0;
        step(4'b0001, 4'b0000, 1'b0);
        repeat (17) step(4'b0000, 4'b0001, 1'b0);
        chk("s17_nwr",   32'(wlog.size()), 32'd16);
        chk("s17_first", 32'(wget(0)),     32'd0);
        chk("s17_last",  32'(wget(15)),    32'd15);
        chk("s17_ndone", 32'(n_done),      32'd1);
        step(4'b1111, 4'b0000, 1'b0);
        chk("s17_rrptr", 32'(gnt_o), 32'b0010);
        repeat (17) step(4'b0000, 4'b1111, 1'b0);

        // All requesters held: round-robin order
        do_reset();
        wlog.delete(); glog.delete();
        for (int i = 0; i < 120 && glog.size() < 5; i++) step(4'b1111, 4'b1111, 1'b0);
        repeat (17) step(4'b0000, 4'b1111, 1'b0);
        chk("s18_ngrant", 32'(glog.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk("s18_order", 32'((i < glog.size()) ? glog[i] : -1), 32'(i % N));
        chk("s18_r2_first", 32'(wget(32)), 32'd1024);
        chk("s18_r2_last",  32'(wget(47)), 32'd1039);

        // Granted requester 1 with gappy valid, requester 0 always valid
        do_reset();
        wlog.delete(); n_done = 0;
        step(4'b0010, 4'b0000, 1'b0);
        tog = 1'b1;
        for (int i = 0; i < 40; i++) begin
            v = {2'b00, tog, 1'b1};
            step(4'b0000, v, 1'b0);
            tog = ~tog;
        end
        chk("s19_nwr",   32'(wlog.size()), 32'd16);
        chk("s19_first", 32'(wget(0)),     32'd512);
        chk("s19_last",  32'(wget(15)),    32'd527);
        chk("s19_ndone", 32'(n_done),      32'd1);

        // Region pointer wrap after 32 bursts
        do_reset();
        wlog.delete();
        for (int b = 0; b < 33; b++) begin
            step(4'b0001, 4'b0000, 1'b0);
            repeat (17) step(4'b0000, 4'b0001, 1'b0);
        end
        chk("s20_nwr",    32'(wlog.size()), 32'd528);
        chk("s20_end",    32'(wget(511)),   32'd511);
        chk("s20_wrap0",  32'(wget(512)),   32'd0);
        chk("s20_wrap15", 32'(wget(527)),   32'd15);

        // Reset after five beats discards the burst
        wlog.delete(); n_done = 0;
        step(4'b0001, 4'b0000, 1'b0);
        repeat (5) step(4'b0000, 4'b0001, 1'b0);
        chk("s21_part", 32'(wget(4)), 32'd20);
        do_reset();
        chk("s21_nodone", 32'(n_done), 32'd0);
        wlog.delete();
        step(4'b0001, 4'b0000, 1'b0);
        repeat (17) step(4'b0000, 4'b0001, 1'b0);
        chk("s21_restart", 32'(wget(0)), 32'd0);

        // Clear during a requester-3 burst applies after it completes
        wlog.delete();
        for (int b = 0; b < 3; b++) begin
            step(4'b1000, 4'b0000, 1'b0);
            repeat (17) step(4'b0000, 4'b1000, 1'b0);
        end
        step(4'b1000, 4'b0000, 1'b0);
        repeat (4) step(4'b0000, 4'b1000, 1'b0);
        step(4'b0000, 4'b1000, 1'b1);
        repeat (12) step(4'b0000, 4'b1000, 1'b0);
        chk("s22_b4_first", 32'(wget(48)), 32'd1584);
        chk("s22_b4_last",  32'(wget(63)), 32'd1599);
        step(4'b1000, 4'b0000, 1'b0);
        repeat (17) step(4'b0000, 4'b1000, 1'b0);
        chk("s22_b5_first", 32'(wget(64)), 32'd1536);
        chk("s22_b5_last",  32'(wget(79)), 32'd1551);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step(4'($urandom()), 4'($urandom()) | 4'($urandom()),
                 ($urandom_range(0, 31) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
